// File: rtl/ttc_int_ctrl14_pkg.sv
// Shared constants for the TTC interrupt controller: register offsets,
// irq FSM state encodings and default sizing.
package ttc_int_ctrl_pkg14;

    localparam int NUM_SRC_DEF   = 3;
    localparam int CNT_W_DEF     = 8;
    localparam int HOLDOFF_W_DEF = 16;

    localparam logic [7:0] ADDR_STATUS  = 8'h00;
    localparam logic [7:0] ADDR_ENABLE  = 8'h04;
    localparam logic [7:0] ADDR_MASKED  = 8'h08;
    localparam logic [7:0] ADDR_HOLDOFF = 8'h0C;
    localparam logic [7:0] ADDR_EVCNT   = 8'h10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ASSERT = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

endpackage

// File: rtl/ttc_int_ctrl14_src.sv
// One interrupt source: rising-edge detect, sticky RW1C status bit and a
// saturating event counter.
module ttc_int_src14 #(
    parameter int CNT_W = 8
) (
    input  logic             pclk14,
    input  logic             n_p_reset14,
    input  logic             level,
    input  logic             w1c,
    input  logic             cnt_clr,
    output logic             status,
    output logic             status_nxt,
    output logic [CNT_W-1:0] cnt
);

    logic             prev;
    logic             rise;
    logic [CNT_W-1:0] cnt_nxt;

    assign rise       = level & ~prev;
    // A rise on the same edge as a clear wins, so no event is lost.
    assign status_nxt = rise | (status & ~w1c);

    always_comb begin
        cnt_nxt = cnt;
        if (cnt_clr) begin
            cnt_nxt = rise ? CNT_W'(1) : '0;
        end else if (rise && (cnt != '1)) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge pclk14 or negedge n_p_reset14) begin
        if (!n_p_reset14) begin
            prev   <= 1'b0;
            status <= 1'b0;
            cnt    <= '0;
        end else begin
            prev   <= level;
            status <= status_nxt;
            cnt    <= cnt_nxt;
        end
    end

endmodule

// File: rtl/ttc_int_ctrl14.sv
// TTC interrupt controller: APB register file, irq hold-off FSM and
// lowest-number-first source encoder.
//
// state     | meaning
// ST_IDLE   | no enabled source pending, irq low
// ST_ASSERT | enabled source pending, irq high
// ST_HOLD   | hold-off after clear, irq forced low until hcnt expires
module ttc_int_ctrl14
    import ttc_int_ctrl_pkg14::*;
#(
    parameter int NUM_SRC   = NUM_SRC_DEF,
    parameter int HOLDOFF_W = HOLDOFF_W_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic               pclk14,
    input  logic               n_p_reset14,
    input  logic               psel14,
    input  logic               penable14,
    input  logic               pwrite14,
    input  logic [7:0]         paddr14,
    input  logic [31:0]        pwdata14,
    input  logic [NUM_SRC:1]   ttc_int14,
    output logic [31:0]        prdata14,
    output logic               irq14,
    output logic [1:0]         irq_id14
);

    logic                     wr_en;
    logic                     rd_setup;
    logic                     rd_access;
    logic [7:0]               addr_w;
    logic                     wr_status;
    logic                     wr_enable;
    logic                     wr_holdoff;
    logic                     wr_evcnt;
    logic [NUM_SRC-1:0]       w1c;
    logic [NUM_SRC-1:0]       status_q;
    logic [NUM_SRC-1:0]       status_nxt;
    logic [NUM_SRC-1:0]       enable_q;
    logic [NUM_SRC-1:0]       enable_nxt;
    logic [NUM_SRC-1:0]       masked_nxt;
    logic                     masked_any;
    logic [HOLDOFF_W-1:0]     holdoff_q;
    logic [HOLDOFF_W-1:0]     hcnt_q;
    logic [HOLDOFF_W-1:0]     hcnt_nxt;
    logic [1:0]               state_q;
    logic [1:0]               state_nxt;
    logic [1:0]               id_nxt;
    logic [NUM_SRC*CNT_W-1:0] evcnt_flat;
    logic [31:0]              rd_val;
    logic                     unused_bits;

    assign unused_bits = &{1'b0, paddr14[1:0], pwdata14[31:HOLDOFF_W]};

    assign wr_en     = psel14 & penable14 & pwrite14;
    assign rd_setup  = psel14 & ~penable14 & ~pwrite14;
    assign rd_access = psel14 & penable14 & ~pwrite14;
    assign addr_w    = {paddr14[7:2], 2'b00};

    assign wr_status  = wr_en && (addr_w == ADDR_STATUS);
    assign wr_enable  = wr_en && (addr_w == ADDR_ENABLE);
    assign wr_holdoff = wr_en && (addr_w == ADDR_HOLDOFF);
    assign wr_evcnt   = wr_en && (addr_w == ADDR_EVCNT);

    assign w1c = wr_status ? pwdata14[NUM_SRC-1:0] : '0;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        ttc_int_src14 #(.CNT_W(CNT_W)) u_src (
            .pclk14      (pclk14),
            .n_p_reset14 (n_p_reset14),
            .level       (ttc_int14[g+1]),
            .w1c         (w1c[g]),
            .cnt_clr     (wr_evcnt),
            .status      (status_q[g]),
            .status_nxt  (status_nxt[g]),
            .cnt         (evcnt_flat[g*CNT_W +: CNT_W])
        );
    end

    assign enable_nxt = wr_enable ? pwdata14[NUM_SRC-1:0] : enable_q;
    // Decisions use post-edge status/enable so a write or rise acts immediately.
    assign masked_nxt = status_nxt & enable_nxt;
    assign masked_any = |masked_nxt;

    always_comb begin
        id_nxt = '0;
        for (int i = NUM_SRC; i >= 1; i--) begin
            if (masked_nxt[i-1]) id_nxt = 2'(i);
        end
    end

    always_comb begin
        rd_val = '0;
        case (addr_w)
            ADDR_STATUS:  rd_val[NUM_SRC-1:0]       = status_q;
            ADDR_ENABLE:  rd_val[NUM_SRC-1:0]       = enable_q;
            ADDR_MASKED:  rd_val[NUM_SRC-1:0]       = status_q & enable_q;
            ADDR_HOLDOFF: rd_val[HOLDOFF_W-1:0]     = holdoff_q;
            ADDR_EVCNT:   rd_val[NUM_SRC*CNT_W-1:0] = evcnt_flat;
            default:      rd_val                    = '0;
        endcase
    end

    always_comb begin
        state_nxt = state_q;
        hcnt_nxt  = hcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (masked_any) state_nxt = ST_ASSERT;
            end
            ST_ASSERT: begin
                if (!masked_any) begin
                    if (holdoff_q == '0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        hcnt_nxt  = holdoff_q;
                        state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                hcnt_nxt = hcnt_q - HOLDOFF_W'(1);
                if (hcnt_q == HOLDOFF_W'(1)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk14 or negedge n_p_reset14) begin
        if (!n_p_reset14) begin
            enable_q  <= '0;
            holdoff_q <= '0;
            hcnt_q    <= '0;
            state_q   <= ST_IDLE;
            irq14     <= 1'b0;
            irq_id14  <= '0;
            prdata14  <= '0;
        end else begin
            enable_q <= enable_nxt;
            if (wr_holdoff) holdoff_q <= pwdata14[HOLDOFF_W-1:0];
            hcnt_q   <= hcnt_nxt;
            state_q  <= state_nxt;
            irq14    <= (state_q == ST_ASSERT);
            irq_id14 <= id_nxt;
            if (rd_setup) begin
                prdata14 <= rd_val;
            end else if (!rd_access) begin
                prdata14 <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ttc_int_ctrl14.sv
// Directed bench for ttc_int_ctrl14: register table plus hand-built
// sequences for latency, hold-off, saturation and same-edge conflicts.
module tb_ttc_int_ctrl14;

    logic        clk;
    logic        rst_n;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [3:1]  ttc;
    logic [31:0] prdata;
    logic        irq;
    logic [1:0]  irq_id;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[18];

    ttc_int_ctrl14 dut (
        .pclk14      (clk),
        .n_p_reset14 (rst_n),
        .psel14      (psel),
        .penable14   (penable),
        .pwrite14    (pwrite),
        .paddr14     (paddr),
        .pwdata14    (pwdata),
        .ttc_int14   (ttc),
        .prdata14    (prdata),
        .irq14       (irq),
        .irq_id14    (irq_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write whose access phase optionally raises ttc lines so a rise
    // coincides with the commit edge.
    task automatic apb_write_pulse(input logic [7:0] a, input logic [31:0] d, input logic [3:1] m);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        tick();
        penable = 1'b1;
        ttc = m;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        ttc = '0;
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        apb_write_pulse(a, d, ttc);
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        tick();
        penable = 1'b1;
        tick();
        d = prdata;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic pulse(input logic [3:1] m);
        ttc = m;
        tick();
        ttc = '0;
    endtask

    initial begin
        logic [31:0] rd;

        tbl[0]  = '{1'b0, 8'h00, 32'h0,        32'h0};
        tbl[1]  = '{1'b0, 8'h04, 32'h0,        32'h0};
        tbl[2]  = '{1'b0, 8'h08, 32'h0,        32'h0};
        tbl[3]  = '{1'b0, 8'h0C, 32'h0,        32'h0};
        tbl[4]  = '{1'b0, 8'h10, 32'h0,        32'h0};
        tbl[5]  = '{1'b0, 8'h14, 32'h0,        32'h0};
        tbl[6]  = '{1'b1, 8'h0C, 32'h1234ABCD, 32'h0};
        tbl[7]  = '{1'b0, 8'h0C, 32'h0,        32'h0000ABCD};
        tbl[8]  = '{1'b1, 8'h04, 32'hFFFFFFFF, 32'h0};
        tbl[9]  = '{1'b0, 8'h04, 32'h0,        32'h7};
        tbl[10] = '{1'b0, 8'h08, 32'h0,        32'h0};
        tbl[11] = '{1'b1, 8'h14, 32'h0000FFFF, 32'h0};
        tbl[12] = '{1'b0, 8'h14, 32'h0,        32'h0};
        tbl[13] = '{1'b1, 8'h00, 32'h7,        32'h0};
        tbl[14] = '{1'b0, 8'h00, 32'h0,        32'h0};
        tbl[15] = '{1'b1, 8'h0C, 32'h0,        32'h0};
        tbl[16] = '{1'b1, 8'h04, 32'h0,        32'h0};
        tbl[17] = '{1'b0, 8'h0F, 32'h0,        32'h0};

        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; ttc = '0;
        repeat (3) tick();
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_irq_id", {30'b0, irq_id}, 32'h0);
        check("rst_prdata", prdata, 32'h0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 18; i++) begin
            if (tbl[i].wr) begin
                apb_write(tbl[i].addr, tbl[i].data);
            end else begin
                apb_read(tbl[i].addr, rd);
                check($sformatf("tbl%0d_rd_%02h", i, tbl[i].addr), rd, tbl[i].exp);
            end
        end
        tick();
        check("prdata_idle_zero", prdata, 32'h0);
        check("tbl_irq_low", {31'b0, irq}, 32'h0);

        // Enabled pulse: irq one cycle after STATUS sets.
        apb_write(8'h04, 32'h2);
        pulse(3'b010);
        check("en_irq_at_n", {31'b0, irq}, 32'h0);
        tick();
        check("en_irq_at_n1", {31'b0, irq}, 32'h1);
        check("en_id_at_n1", {30'b0, irq_id}, 32'h2);
        apb_read(8'h00, rd);
        check("en_status", rd, 32'h2);
        apb_write(8'h00, 32'h2);
        check("en_clr_irq_at_m", {31'b0, irq}, 32'h1);
        tick();
        check("en_clr_irq_at_m1", {31'b0, irq}, 32'h0);
        check("en_clr_id", {30'b0, irq_id}, 32'h0);

        // Masked source, then enabled later.
        apb_write(8'h04, 32'h0);
        pulse(3'b001);
        repeat (3) tick();
        check("msk_irq_low", {31'b0, irq}, 32'h0);
        check("msk_id_zero", {30'b0, irq_id}, 32'h0);
        apb_read(8'h00, rd);
        check("msk_status", rd, 32'h1);
        apb_read(8'h08, rd);
        check("msk_masked", rd, 32'h0);
        apb_write(8'h04, 32'h1);
        check("msk_en_irq_at_m", {31'b0, irq}, 32'h0);
        tick();
        check("msk_en_irq_at_m1", {31'b0, irq}, 32'h1);
        check("msk_en_id", {30'b0, irq_id}, 32'h1);
        apb_read(8'h08, rd);
        check("msk_masked_set", rd, 32'h1);
        apb_write(8'h00, 32'h1);
        repeat (2) tick();

        // Hold-off of 5: FSM spends 5 cycles in HOLD plus one in IDLE
        // before re-asserting, so irq is low on 6 samples after the clear.
        apb_write(8'h0C, 32'h5);
        apb_write(8'h04, 32'h7);
        pulse(3'b100);
        tick();
        check("ho_irq_first", {31'b0, irq}, 32'h1);
        check("ho_id_first", {30'b0, irq_id}, 32'h3);
        apb_write(8'h00, 32'h4);
        check("ho_irq_at_clr", {31'b0, irq}, 32'h1);
        pulse(3'b100);
        for (int k = 1; k <= 7; k++) begin
            if (k > 1) tick();
            check($sformatf("ho_irq_c%0d", k), {31'b0, irq}, (k == 7) ? 32'h1 : 32'h0);
        end
        check("ho_id_second", {30'b0, irq_id}, 32'h3);
        apb_write(8'h0C, 32'h0);
        apb_write(8'h00, 32'h7);
        repeat (2) tick();
        check("ho_irq_cleared", {31'b0, irq}, 32'h0);

        // Counter saturation: cnt1 = 1 + 300 -> 255, cnt2 = 1, cnt3 = 2.
        apb_write(8'h04, 32'h0);
        for (int k = 0; k < 300; k++) begin
            ttc = 3'b001;
            tick();
            ttc = '0;
            tick();
        end
        apb_read(8'h10, rd);
        check("sat_evcnt", rd, 32'h000201FF);
        apb_write_pulse(8'h10, 32'h0, 3'b001);
        apb_read(8'h10, rd);
        check("evclr_with_rise", rd, 32'h00000001);

        // Same-edge W1C and rise on source 1.
        apb_write(8'h00, 32'h7);
        apb_write(8'h04, 32'h1);
        pulse(3'b001);
        tick();
        check("se_irq_before", {31'b0, irq}, 32'h1);
        apb_write_pulse(8'h00, 32'h1, 3'b001);
        check("se_irq_at_m", {31'b0, irq}, 32'h1);
        tick();
        check("se_irq_at_m1", {31'b0, irq}, 32'h1);
        tick();
        check("se_irq_at_m2", {31'b0, irq}, 32'h1);
        apb_read(8'h00, rd);
        check("se_status", rd, 32'h1);

        // Reset mid-interrupt with source 2 held high through release.
        rst_n = 1'b0;
        ttc = 3'b010;
        tick();
        check("rst2_irq", {31'b0, irq}, 32'h0);
        check("rst2_id", {30'b0, irq_id}, 32'h0);
        rst_n = 1'b1;
        tick();
        tick();
        apb_read(8'h00, rd);
        check("rst2_status_edge", rd, 32'h2);
        apb_read(8'h10, rd);
        check("rst2_evcnt", rd, 32'h00000100);
        apb_read(8'h04, rd);
        check("rst2_enable", rd, 32'h0);
        check("rst2_irq_after", {31'b0, irq}, 32'h0);
        ttc = '0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
